// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register-bus slice: bus direction/status encodings
// and the AXI4-Lite adapter state machine.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    // AXI response encoding so status can be returned on B/R without translation
    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE,
        BUS_ACCESS,
        WAIT_B,
        WAIT_R
    } rggen_adapter_state;

endpackage

// File: rtl/rggen_bus_if.sv
// Single-outstanding register bus between a host adapter and rggen_bus_splitter.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    import rggen_rtl_pkg::*;

    logic                        request;
    logic [ADDRESS_WIDTH-1:0]    address;
    rggen_direction              direction;
    logic [DATA_WIDTH-1:0]       write_data;
    logic [DATA_WIDTH/8-1:0]     write_strobe;
    logic                        done;
    logic [DATA_WIDTH-1:0]       read_data;
    rggen_status                 status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_data, status
    );

endinterface

// File: rtl/rggen_axi4lite_adapter.sv
// AXI4-Lite slave to rggen_bus_if master: 1-entry AW/W/AR buffers, alternating
// read/write arbitration, one bus access in flight, B/R held until accepted.
module rggen_axi4lite_adapter
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [ADDRESS_WIDTH-1:0]    awaddr,
    input  logic [2:0]                  awprot,
    input  logic                        wvalid,
    output logic                        wready,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [DATA_WIDTH/8-1:0]     wstrb,
    output logic                        bvalid,
    input  logic                        bready,
    output logic [1:0]                  bresp,
    input  logic                        arvalid,
    output logic                        arready,
    input  logic [ADDRESS_WIDTH-1:0]    araddr,
    input  logic [2:0]                  arprot,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [1:0]                  rresp,
    rggen_bus_if.master                 bus_if
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ADDRESS_WIDTH'(STROBE_WIDTH - 1);

    rggen_adapter_state             state_q, state_d;
    logic                           aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic                           awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic [ADDRESS_WIDTH-1:0]       aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0]          w_data_q, w_data_d;
    logic [STROBE_WIDTH-1:0]        w_strb_q, w_strb_d;
    logic                           prefer_write_q, prefer_write_d;
    logic [ADDRESS_WIDTH-1:0]       addr_q, addr_d;
    rggen_direction                 dir_q, dir_d;
    logic [DATA_WIDTH-1:0]          wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STROBE_WIDTH-1:0]        wstrb_q, wstrb_d;
    logic [1:0]                     resp_q, resp_d;
    logic                           aw_hs, w_hs, ar_hs, wr_ok, rd_ok, grant_wr;
    logic                           unused_prot;

    assign unused_prot = ^{awprot, arprot};

    always_comb begin
        state_d        = state_q;
        aw_full_d      = aw_full_q;
        w_full_d       = w_full_q;
        ar_full_d      = ar_full_q;
        aw_addr_d      = aw_addr_q;
        ar_addr_d      = ar_addr_q;
        w_data_d       = w_data_q;
        w_strb_d       = w_strb_q;
        prefer_write_d = prefer_write_q;
        addr_d         = addr_q;
        dir_d          = dir_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        rdata_d        = rdata_q;
        resp_d         = resp_q;
        wr_ok          = 1'b0;
        rd_ok          = 1'b0;
        grant_wr       = 1'b0;

        aw_hs = awvalid && awready_q;
        w_hs  = wvalid  && wready_q;
        ar_hs = arvalid && arready_q;
        if (aw_hs) begin aw_full_d = 1'b1; aw_addr_d = awaddr; end
        if (w_hs)  begin w_full_d  = 1'b1; w_data_d = wdata; w_strb_d = wstrb; end
        if (ar_hs) begin ar_full_d = 1'b1; ar_addr_d = araddr; end

        case (state_q)
            IDLE: begin
                // A handshake in this cycle makes its buffer eligible immediately (bypass)
                wr_ok    = (aw_full_q || aw_hs) && (w_full_q || w_hs);
                rd_ok    = ar_full_q || ar_hs;
                grant_wr = wr_ok && (!rd_ok || prefer_write_q);
                if (wr_ok && rd_ok) prefer_write_d = !prefer_write_q;
                if (grant_wr) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    addr_d    = (aw_full_q ? aw_addr_q : awaddr) & ~ADDR_MASK;
                    dir_d     = RGGEN_WRITE;
                    wdata_d   = w_full_q ? w_data_q : wdata;
                    wstrb_d   = w_full_q ? w_strb_q : wstrb;
                    state_d   = BUS_ACCESS;
                end else if (rd_ok) begin
                    ar_full_d = 1'b0;
                    addr_d    = (ar_full_q ? ar_addr_q : araddr) & ~ADDR_MASK;
                    dir_d     = RGGEN_READ;
                    wdata_d   = '0;
                    wstrb_d   = '0;
                    state_d   = BUS_ACCESS;
                end
            end
            BUS_ACCESS: begin
                if (bus_if.done) begin
                    resp_d = bus_if.status;
                    if (dir_q == RGGEN_READ) rdata_d = bus_if.read_data;
                    state_d = (dir_q == RGGEN_WRITE) ? WAIT_B : WAIT_R;
                end
            end
            WAIT_B:  if (bready) state_d = IDLE;
            WAIT_R:  if (rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !ar_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            aw_full_q      <= 1'b0;
            w_full_q       <= 1'b0;
            ar_full_q      <= 1'b0;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            arready_q      <= 1'b0;
            aw_addr_q      <= '0;
            ar_addr_q      <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            prefer_write_q <= 1'b1;
            addr_q         <= '0;
            dir_q          <= RGGEN_READ;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            rdata_q        <= '0;
            resp_q         <= '0;
        end else begin
            state_q        <= state_d;
            aw_full_q      <= aw_full_d;
            w_full_q       <= w_full_d;
            ar_full_q      <= ar_full_d;
            awready_q      <= awready_d;
            wready_q       <= wready_d;
            arready_q      <= arready_d;
            aw_addr_q      <= aw_addr_d;
            ar_addr_q      <= ar_addr_d;
            w_data_q       <= w_data_d;
            w_strb_q       <= w_strb_d;
            prefer_write_q <= prefer_write_d;
            addr_q         <= addr_d;
            dir_q          <= dir_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            rdata_q        <= rdata_d;
            resp_q         <= resp_d;
        end
    end

    assign awready             = awready_q;
    assign wready              = wready_q;
    assign arready             = arready_q;
    assign bvalid              = (state_q == WAIT_B);
    assign rvalid              = (state_q == WAIT_R);
    assign bresp               = resp_q;
    assign rresp               = resp_q;
    assign rdata               = rdata_q;
    assign bus_if.request      = (state_q == BUS_ACCESS);
    assign bus_if.address      = addr_q;
    assign bus_if.direction    = dir_q;
    assign bus_if.write_data   = wdata_q;
    assign bus_if.write_strobe = wstrb_q;

    a_request_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus_if.request && !bus_if.done) |=> (bus_if.request && $stable(bus_if.address) &&
        $stable(bus_if.direction) && $stable(bus_if.write_data) && $stable(bus_if.write_strobe)));
    a_resp_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(bvalid && rvalid));
    a_done_in_request: assert property (@(posedge clk) disable iff (!rst_n) bus_if.done |-> bus_if.request);

endmodule

// File: tb/tb_rggen_axi4lite_adapter.sv
// Bench for rggen_axi4lite_adapter: splitter stub with variable latency, transaction-level
// register model, directed scenarios plus randomized read/write traffic.
module tb_rggen_axi4lite_adapter;
    import rggen_rtl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [15:0] awaddr = 0, araddr = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0]  wstrb = 0;
    logic [1:0]  bresp, rresp;

    int total = 0;
    int bad = 0;

    rggen_bus_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus_if ();

    rggen_axi4lite_adapter #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(3'b000),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(3'b000),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .bus_if(bus_if)
    );

    // ---------------- splitter stub: 64 words at 0x0000-0x00FF, rest unmapped
    typedef struct packed {
        logic        dir;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } acc_t;

    acc_t        log_q[$];
    acc_t        first_acc;
    logic [31:0] stub_mem [64] = '{default: 32'h0};
    int          stub_lat = 0;
    int          stub_cnt;
    bit          seen;
    int          stab_viol = 0;

    function automatic acc_t cur_acc();
        return '{dir: (bus_if.direction == RGGEN_WRITE), addr: bus_if.address,
                 data: bus_if.write_data, strb: bus_if.write_strobe};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_if.done      <= 1'b0;
            bus_if.read_data <= '0;
            bus_if.status    <= RGGEN_OKAY;
            stub_cnt         <= 0;
            seen             <= 1'b0;
        end else if (bus_if.done) begin
            bus_if.done <= 1'b0;
            seen        <= 1'b0;
            stub_cnt    <= 0;
        end else if (bus_if.request) begin
            if (!seen) begin
                first_acc <= cur_acc();
                seen      <= 1'b1;
            end else if (cur_acc() != first_acc) begin
                stab_viol <= stab_viol + 1;
            end
            if (stub_cnt >= stub_lat) begin
                bus_if.done <= 1'b1;
                log_q.push_back(cur_acc());
                if (bus_if.address < 16'h0100) begin
                    bus_if.status <= RGGEN_OKAY;
                    if (bus_if.direction == RGGEN_WRITE) begin
                        stub_mem[bus_if.address[7:2]] <= merge(stub_mem[bus_if.address[7:2]],
                                                               bus_if.write_data, bus_if.write_strobe);
                        bus_if.read_data <= '0;
                    end else begin
                        bus_if.read_data <= stub_mem[bus_if.address[7:2]];
                    end
                end else begin
                    bus_if.status    <= RGGEN_SLAVE_ERROR;
                    bus_if.read_data <= '0;
                end
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    // ---------------- reference model: byte-addressed register map + arbitration pointer
    logic [7:0] ref_bytes [256] = '{default: 8'h0};
    bit         ptr_write = 1'b1;

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        int unsigned base;
        if (a >= 16'h0100) return 32'h0;
        base = int'(a) / 4 * 4;
        return {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
    endfunction

    task automatic ref_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned base;
        if (a >= 16'h0100) return;
        base = int'(a) / 4 * 4;
        for (int i = 0; i < 4; i++)
            if (s[i]) ref_bytes[base + i] = d[8*i +: 8];
    endtask

    function automatic logic [1:0] exp_resp(input logic [15:0] a);
        return (a < 16'h0100) ? 2'b00 : 2'b10;
    endfunction

    // ---------------- AXI drivers (inputs driven #1 after the edge, outputs sampled there)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [15:0] a, input int dly);
        bit got;
        int n = 0;
        repeat (dly) tick();
        awaddr = a; awvalid = 1;
        do begin got = awready; tick(); n++; end while (!got && n < 100);
        awvalid = 0;
        if (!got) begin total++; bad++; $display("FAIL aw_handshake got=timeout want=accept"); end
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        bit got;
        int n = 0;
        repeat (dly) tick();
        wdata = d; wstrb = s; wvalid = 1;
        do begin got = wready; tick(); n++; end while (!got && n < 100);
        wvalid = 0;
        if (!got) begin total++; bad++; $display("FAIL w_handshake got=timeout want=accept"); end
    endtask

    task automatic send_ar(input logic [15:0] a, input int dly);
        bit got;
        int n = 0;
        repeat (dly) tick();
        araddr = a; arvalid = 1;
        do begin got = arready; tick(); n++; end while (!got && n < 100);
        arvalid = 0;
        if (!got) begin total++; bad++; $display("FAIL ar_handshake got=timeout want=accept"); end
    endtask

    task automatic wait_b(input int dly, output logic [1:0] resp);
        int n = 0;
        while (!bvalid && n < 100) begin tick(); n++; end
        if (!bvalid) begin total++; bad++; $display("FAIL bvalid_wait got=timeout want=bvalid"); end
        resp = bresp;
        repeat (dly) tick();
        bready = 1; tick(); bready = 0;
    endtask

    task automatic wait_r(input int dly, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        while (!rvalid && n < 100) begin tick(); n++; end
        if (!rvalid) begin total++; bad++; $display("FAIL rvalid_wait got=timeout want=rvalid"); end
        d = rdata; resp = rresp;
        repeat (dly) tick();
        rready = 1; tick(); rready = 0;
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, input int bd, output logic [1:0] resp);
        fork
            send_aw(a, awd);
            send_w(d, s, wd);
        join
        wait_b(bd, resp);
    endtask

    task automatic axi_read(input logic [15:0] a, input int ard, input int rd,
                            output logic [31:0] d, output logic [1:0] resp);
        send_ar(a, ard);
        wait_r(rd, d, resp);
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst_n = 0;
        tick();
        total++;
        if ({awready, wready, arready, bvalid, rvalid, bus_if.request} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000", {awready, wready, arready, bvalid, rvalid, bus_if.request});
        end
        total++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            bad++; $display("FAIL reset_payload got=%h want=0", {bresp, rresp, rdata});
        end
        rst_n = 1; ptr_write = 1;
        tick();
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++; $display("FAIL ready_after_reset got=%b want=111", {awready, wready, arready});
        end
    endtask

    task automatic test_single_write();
        logic [1:0] r; logic [31:0] d; int n0 = log_q.size();
        stub_lat = 0;
        axi_write(16'h0004, 32'hDEADBEEF, 4'hF, 0, 3, 0, r);
        ref_wr(16'h0004, 32'hDEADBEEF, 4'hF);
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL t1_bresp got=%b want=00", r); end
        total++;
        if (log_q.size() - n0 !== 1) begin bad++; $display("FAIL t1_requests got=%0d want=1", log_q.size() - n0); end
        axi_read(16'h0004, 0, 0, d, r);
        total++;
        if (d !== ref_rd(16'h0004)) begin bad++; $display("FAIL t1_readback got=%h want=%h", d, ref_rd(16'h0004)); end
    endtask

    task automatic test_arbitration();
        for (int rnd = 0; rnd < 2; rnd++) begin
            logic [31:0] d = $urandom, old_v = ref_rd(16'h0040), rd_v = 0, exp_rd;
            logic [1:0]  b = 2'bxx;
            bit          got_b = 0, got_r = 0, wfirst;
            int          n0 = log_q.size(), n = 0;
            awaddr = 16'h0040; araddr = 16'h0040; wdata = d; wstrb = 4'hF;
            awvalid = 1; wvalid = 1; arvalid = 1;
            tick();
            awvalid = 0; wvalid = 0; arvalid = 0;
            bready = 1; rready = 1;
            while (!(got_b && got_r) && n < 60) begin
                if (bvalid) begin got_b = 1; b = bresp; end
                if (rvalid) begin got_r = 1; rd_v = rdata; end
                tick(); n++;
            end
            bready = 0; rready = 0;
            wfirst = ptr_write;
            ptr_write = !ptr_write;
            exp_rd = wfirst ? d : old_v;
            ref_wr(16'h0040, d, 4'hF);
            total++;
            if (!(got_b && got_r)) begin bad++; $display("FAIL arb_responses got=b%0d_r%0d want=b1_r1", got_b, got_r); end
            total++;
            if (log_q.size() < n0 + 2) begin
                bad++; $display("FAIL arb_count got=%0d want=2", log_q.size() - n0);
            end else if (log_q[n0].dir !== wfirst || log_q[n0 + 1].dir !== !wfirst) begin
                bad++; $display("FAIL arb_order got=%b%b want=%b%b", log_q[n0].dir, log_q[n0 + 1].dir, wfirst, !wfirst);
            end
            total++;
            if (rd_v !== exp_rd || b !== 2'b00) begin
                bad++; $display("FAIL arb_data got=%h/%b want=%h/00", rd_v, b, exp_rd);
            end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d0; logic [1:0] r0; int n = 0;
        send_ar(16'hFFF0, 0);
        while (!rvalid && n < 100) begin tick(); n++; end
        d0 = rdata; r0 = rresp;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rvalid !== 1'b1 || rdata !== d0 || rresp !== r0) begin
                bad++; $display("FAIL t3_r_hold got=%b/%h/%b want=1/%h/%b", rvalid, rdata, rresp, d0, r0);
            end
            tick();
        end
        rready = 1; tick(); rready = 0;
        total++;
        if (r0 !== exp_resp(16'hFFF0) || d0 !== ref_rd(16'hFFF0)) begin
            bad++; $display("FAIL t3_unmapped_read got=%b/%h want=10/00000000", r0, d0);
        end
        axi_write(16'h8000, 32'h12345678, 4'hF, 1, 0, 0, r0);
        total++;
        if (r0 !== exp_resp(16'h8000)) begin bad++; $display("FAIL t3_unmapped_write got=%b want=10", r0); end
    endtask

    task automatic test_b_stall();
        logic [1:0] b0, r; logic [31:0] d; int n0, n = 0; bit acc = 0;
        fork
            send_aw(16'h0020, 0);
            send_w(32'hA5A5_0F0F, 4'hF, 1);
        join
        ref_wr(16'h0020, 32'hA5A5_0F0F, 4'hF);
        while (!bvalid && n < 100) begin tick(); n++; end
        b0 = bresp; n0 = log_q.size();
        araddr = 16'h0020; arvalid = 1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bvalid !== 1'b1 || bresp !== b0 || bus_if.request !== 1'b0 || log_q.size() != n0) begin
                bad++; $display("FAIL t4_b_hold got=%b/%b/%b/%0d want=1/%b/0/%0d", bvalid, bresp, bus_if.request, log_q.size(), b0, n0);
            end
            if (arvalid && arready) acc = 1;
            tick();
            if (acc) arvalid = 0;
        end
        arvalid = 0;
        total++;
        if (acc !== 1'b1 || b0 !== 2'b00) begin bad++; $display("FAIL t4_ar_accept got=%b/%b want=1/00", acc, b0); end
        bready = 1; tick(); bready = 0;
        wait_r(0, d, r);
        total++;
        if (d !== ref_rd(16'h0020) || r !== 2'b00) begin
            bad++; $display("FAIL t4_read got=%h/%b want=%h/00", d, r, ref_rd(16'h0020));
        end
    endtask

    task automatic test_addr_mask();
        logic [1:0] r; logic [31:0] d;
        axi_write(16'h0013, 32'h0000_7700, 4'b0010, 0, 0, 0, r);
        ref_wr(16'h0013, 32'h0000_7700, 4'b0010);
        total++;
        if (log_q[$].addr !== 16'h0010 || log_q[$].strb !== 4'b0010 || r !== 2'b00) begin
            bad++; $display("FAIL t5_addr_strobe got=%h/%b/%b want=0010/0010/00", log_q[$].addr, log_q[$].strb, r);
        end
        axi_read(16'h0010, 0, 0, d, r);
        total++;
        if (d !== ref_rd(16'h0010)) begin bad++; $display("FAIL t5_readback got=%h want=%h", d, ref_rd(16'h0010)); end
    endtask

    task automatic test_random(input int count);
        for (int k = 0; k < count; k++) begin
            logic [15:0] a; logic [31:0] d, got_d; logic [3:0] s; logic [1:0] r; acc_t e;
            a = ($urandom_range(0, 7) == 0) ? 16'(16'h0100 + $urandom_range(0, 16'hFEFF)) : 16'($urandom_range(0, 255));
            stub_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r);
                ref_wr(a, d, s);
                e = '{dir: 1'b1, addr: a & 16'hFFFC, data: d, strb: s};
                total++;
                if (r !== exp_resp(a) || log_q[$] !== e) begin
                    bad++; $display("FAIL rnd_write a=%h got=%b/%h want=%b/%h", a, r, log_q[$], exp_resp(a), e);
                end
            end else begin
                axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3), got_d, r);
                e = '{dir: 1'b0, addr: a & 16'hFFFC, data: 32'h0, strb: 4'h0};
                total++;
                if (r !== exp_resp(a) || got_d !== ref_rd(a) || log_q[$] !== e) begin
                    bad++; $display("FAIL rnd_read a=%h got=%b/%h/%h want=%b/%h/%h", a, r, got_d, log_q[$], exp_resp(a), ref_rd(a), e);
                end
            end
        end
        total++;
        if (stab_viol !== 0) begin bad++; $display("FAIL request_stability got=%0d want=0", stab_viol); end
    endtask

    task automatic test_reset_mid_access();
        logic [1:0] r; logic [31:0] d; int n = 0; bit seen_resp = 0;
        stub_lat = 8;
        fork
            send_aw(16'h0030, 0);
            send_w(32'hCAFE_F00D, 4'hF, 0);
        join
        while (!bus_if.request && n < 20) begin tick(); n++; end
        total++;
        if (bus_if.request !== 1'b1) begin bad++; $display("FAIL t6_request got=0 want=1"); end
        tick();
        rst_n = 0;
        tick();
        total++;
        if (bus_if.request !== 1'b0 || bvalid !== 1'b0) begin
            bad++; $display("FAIL t6_abandon got=%b/%b want=0/0", bus_if.request, bvalid);
        end
        rst_n = 1; ptr_write = 1; stub_lat = 1;
        repeat (10) begin
            if (bvalid || rvalid) seen_resp = 1;
            tick();
        end
        total++;
        if (seen_resp !== 1'b0) begin bad++; $display("FAIL t6_no_response got=1 want=0"); end
        axi_read(16'h0030, 0, 0, d, r);
        total++;
        if (d !== ref_rd(16'h0030)) begin bad++; $display("FAIL t6_unchanged got=%h want=%h", d, ref_rd(16'h0030)); end
        axi_write(16'h0030, 32'h0BAD_CAFE, 4'hF, 0, 2, 1, r);
        ref_wr(16'h0030, 32'h0BAD_CAFE, 4'hF);
        axi_read(16'h0030, 1, 0, d, r);
        total++;
        if (d !== ref_rd(16'h0030) || r !== 2'b00) begin
            bad++; $display("FAIL t6_fresh got=%h/%b want=%h/00", d, r, ref_rd(16'h0030));
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_write();
        test_arbitration();
        test_unmapped();
        test_b_stall();
        test_addr_mask();
        test_random(40);
        test_reset_mid_access();
        test_arbitration();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
